// File: rtl/ysyx_rnu.sv
// Register-rename unit: alias table, ROB tag allocator and a one-entry output slot.
// Optional feature: define YSYX_RNU_BYPASS_EN to zero a looked-up tag that commits in the fire cycle.
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 8
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_rnu #(
    parameter int RLEN     = `YSYX_REG_LEN,
    parameter int ROB_SIZE = `YSYX_ROB_SIZE,
    parameter int XLEN     = `YSYX_XLEN,
    localparam int TW      = $clog2(ROB_SIZE) + 1
) (
    input  logic            clock,
    input  logic            reset,
    // decode side: in_valid/in_ready handshake, transfer when both are high
    input  logic            in_valid,
    input  logic [RLEN-1:0] in_rd,
    input  logic [RLEN-1:0] in_rs1,
    input  logic [RLEN-1:0] in_rs2,
    input  logic            in_wen,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            in_ready,
    // issue side: payload held stable while out_valid && !out_ready
    output logic            out_valid,
    output logic [TW-1:0]   out_qj,
    output logic [TW-1:0]   out_qk,
    output logic [TW-1:0]   out_dest,
    output logic [RLEN-1:0] out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    input  logic            out_ready,
    input  logic            cmt_valid,
    input  logic [RLEN-1:0] cmt_rd,
    input  logic [TW-1:0]   cmt_dest,
    input  logic            flush
);

    localparam int NREG = 1 << RLEN;
    localparam logic [TW-1:0] ROB_MAX = TW'(ROB_SIZE);
    localparam logic [TW-1:0] ONE     = TW'(1);

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

    typedef struct packed {
        logic [TW-1:0]   qj;
        logic [TW-1:0]   qk;
        logic [TW-1:0]   dest;
        logic [RLEN-1:0] rd;
        logic            wen;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } payload_t;

    slot_e           slot_q, slot_d;
    payload_t        pay_q, pay_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [TW-1:0]   tag_q [NREG];
    logic [TW-1:0]   tag_d [NREG];
    logic [TW-1:0]   alloc_q, alloc_d;
    logic [TW-1:0]   cnt_q, cnt_d;

    logic            fire;
    logic            cmt_ok;
    logic [TW-1:0]   qj_raw, qk_raw, qj_d, qk_d;

    assign in_ready = !flush && (cnt_q < ROB_MAX) && (slot_q == SLOT_EMPTY || out_ready);
    assign fire     = in_valid && in_ready;
    assign cmt_ok   = cmt_valid && (cnt_q != '0);

    // x0 is never renamed, so its lookup is forced to "ready"
    always_comb begin
        qj_raw = '0;
        qk_raw = '0;
        if (in_rs1 != '0 && busy_q[in_rs1]) qj_raw = tag_q[in_rs1];
        if (in_rs2 != '0 && busy_q[in_rs2]) qk_raw = tag_q[in_rs2];
`ifdef YSYX_RNU_BYPASS_EN
        qj_d = (cmt_valid && qj_raw == cmt_dest) ? '0 : qj_raw;
        qk_d = (cmt_valid && qk_raw == cmt_dest) ? '0 : qk_raw;
`else
        qj_d = qj_raw;
        qk_d = qk_raw;
`endif
    end

    // rename state; the rename write is applied after the commit clear so it wins
    always_comb begin
        busy_d  = busy_q;
        tag_d   = tag_q;
        alloc_d = alloc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            busy_d  = '0;
            alloc_d = ONE;
            cnt_d   = '0;
        end else begin
            if (cmt_valid && cmt_rd != '0 && tag_q[cmt_rd] == cmt_dest) begin
                busy_d[cmt_rd] = 1'b0;
            end
            if (fire && in_wen && in_rd != '0) begin
                busy_d[in_rd] = 1'b1;
                tag_d[in_rd]  = alloc_q;
            end
            if (fire) begin
                alloc_d = (alloc_q == ROB_MAX) ? ONE : alloc_q + ONE;
            end
            case ({fire, cmt_ok})
                2'b10:   cnt_d = cnt_q + ONE;
                2'b01:   cnt_d = cnt_q - ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        slot_d = slot_q;
        pay_d  = pay_q;
        case (slot_q)
            SLOT_EMPTY: if (fire) slot_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !fire) slot_d = SLOT_EMPTY;
            default:    slot_d = SLOT_EMPTY;
        endcase
        if (fire) begin
            pay_d.qj   = qj_d;
            pay_d.qk   = qk_d;
            pay_d.dest = alloc_q;
            pay_d.rd   = in_rd;
            pay_d.wen  = in_wen;
            pay_d.pc   = in_pc;
            pay_d.inst = in_inst;
        end
        if (flush) slot_d = SLOT_EMPTY;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q  <= SLOT_EMPTY;
            pay_q   <= '0;
            busy_q  <= '0;
            alloc_q <= ONE;
            cnt_q   <= '0;
            for (int i = 0; i < NREG; i++) tag_q[i] <= '0;
        end else begin
            slot_q  <= slot_d;
            pay_q   <= pay_d;
            busy_q  <= busy_d;
            alloc_q <= alloc_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NREG; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign out_valid = (slot_q == SLOT_FULL);
    assign out_qj    = pay_q.qj;
    assign out_qk    = pay_q.qk;
    assign out_dest  = pay_q.dest;
    assign out_rd    = pay_q.rd;
    assign out_wen   = pay_q.wen;
    assign out_pc    = pay_q.pc;
    assign out_inst  = pay_q.inst;

endmodule

// File: tb/tb_ysyx_rnu.sv
// Bench for ysyx_rnu: rename vector table plus hand-written stall, wrap, commit and flush sequences.
module tb_ysyx_rnu;

    localparam int RLEN = 5;
    localparam int ROB  = 8;
    localparam int XLEN = 32;
    localparam int TW   = $clog2(ROB) + 1;
    localparam int EW   = 3 * TW + RLEN + 1 + XLEN + 32;
`ifdef YSYX_RNU_BYPASS_EN
    localparam logic [TW-1:0] BYP_QJ = '0;
`else
    localparam logic [TW-1:0] BYP_QJ = TW'(2);
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [RLEN-1:0] in_rd, in_rs1, in_rs2;
    logic            in_wen;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            in_ready;
    logic            out_valid;
    logic [TW-1:0]   out_qj, out_qk, out_dest;
    logic [RLEN-1:0] out_rd;
    logic            out_wen;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            out_ready;
    logic            cmt_valid;
    logic [RLEN-1:0] cmt_rd;
    logic [TW-1:0]   cmt_dest;
    logic            flush;

    ysyx_rnu #(.RLEN(RLEN), .ROB_SIZE(ROB), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_wen(in_wen), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_qj(out_qj), .out_qk(out_qk), .out_dest(out_dest),
        .out_rd(out_rd), .out_wen(out_wen), .out_pc(out_pc), .out_inst(out_inst),
        .out_ready(out_ready),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_dest(cmt_dest), .flush(flush)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [RLEN-1:0] rd, rs1, rs2;
        logic            wen;
        logic [TW-1:0]   qj, qk, dest;
    } vec_t;

    vec_t          vecs [8];
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] last_exp;
    int            n_cmp = 0;
    int            n_err = 0;
    int            seq   = 0;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic [RLEN-1:0] rd, input logic [RLEN-1:0] rs1,
                         input logic [RLEN-1:0] rs2, input logic wen);
        in_valid = 1'b1;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_wen   = wen;
        in_pc    = 32'h8000_0000 + 32'(seq * 4);
        in_inst  = $urandom;
        seq++;
    endtask

    task automatic push(input logic [TW-1:0] qj, input logic [TW-1:0] qk, input logic [TW-1:0] dest);
        exp_q.push_back({qj, qk, dest, in_rd, in_wen, in_pc, in_inst});
    endtask

    task automatic check_out();
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_fields: got output, expected queue empty");
        end else begin
            last_exp = exp_q.pop_front();
            chk("out_valid", 128'(out_valid), 128'(1'b1));
            chk("out_fields", 128'({out_qj, out_qk, out_dest, out_rd, out_wen, out_pc, out_inst}),
                128'(last_exp));
        end
    endtask

    task automatic fire_one(input logic [RLEN-1:0] rd, input logic [RLEN-1:0] rs1,
                            input logic [RLEN-1:0] rs2, input logic wen,
                            input logic [TW-1:0] qj, input logic [TW-1:0] qk,
                            input logic [TW-1:0] dest);
        drive(rd, rs1, rs2, wen);
        #1;
        chk("in_ready_fire", 128'(in_ready), 128'(1'b1));
        push(qj, qk, dest);
        cyc();
        check_out();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{rd: 1, rs1: 0, rs2: 0, wen: 1, qj: 0, qk: 0, dest: 1};
        vecs[1] = '{rd: 2, rs1: 1, rs2: 0, wen: 1, qj: 1, qk: 0, dest: 2};
        vecs[2] = '{rd: 0, rs1: 2, rs2: 1, wen: 1, qj: 2, qk: 1, dest: 3};
        vecs[3] = '{rd: 1, rs1: 1, rs2: 2, wen: 0, qj: 1, qk: 2, dest: 4};
        vecs[4] = '{rd: 1, rs1: 0, rs2: 1, wen: 1, qj: 0, qk: 1, dest: 5};
        vecs[5] = '{rd: 3, rs1: 1, rs2: 0, wen: 1, qj: 5, qk: 0, dest: 6};
        vecs[6] = '{rd: 4, rs1: 3, rs2: 4, wen: 1, qj: 6, qk: 0, dest: 7};
        vecs[7] = '{rd: 5, rs1: 4, rs2: 1, wen: 0, qj: 7, qk: 5, dest: 8};

        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_wen = 1'b0;
        in_pc = '0; in_inst = '0; out_ready = 1'b1; cmt_valid = 1'b0; cmt_rd = '0;
        cmt_dest = '0; flush = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_fields", 128'({out_qj, out_qk, out_dest, out_rd, out_wen, out_pc, out_inst}), 128'(0));

        // back-to-back renames until the ROB is full
        for (int i = 0; i < 8; i++) begin
            fire_one(vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].wen,
                     vecs[i].qj, vecs[i].qk, vecs[i].dest);
        end

        // full: no fire; a stale commit of x1 frees a slot but keeps x1 busy
        drive(3, 0, 0, 1);
        cmt_valid = 1'b1; cmt_rd = 1; cmt_dest = 1;
        #1;
        chk("in_ready_full", 128'(in_ready), 128'(1'b0));
        cyc();
        cmt_valid = 1'b0;
        chk("slot_drained", 128'(out_valid), 128'(1'b0));
        fire_one(0, 1, 0, 0, 5, 0, 1);

        flush = 1'b1;
        #1;
        chk("in_ready_flush", 128'(in_ready), 128'(1'b0));
        cyc();
        flush = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(1'b0));

        // tag[5]=3 then stale and matching commits
        fire_one(5, 0, 0, 1, 0, 0, 1);
        fire_one(6, 0, 0, 1, 0, 0, 2);
        fire_one(5, 0, 0, 1, 0, 0, 3);
        cmt_valid = 1'b1; cmt_rd = 5; cmt_dest = 2;
        cyc();
        cmt_valid = 1'b0;
        fire_one(0, 5, 0, 0, 3, 0, 4);
        cmt_valid = 1'b1; cmt_rd = 5; cmt_dest = 3;
        cyc();
        cmt_valid = 1'b0;
        fire_one(0, 5, 0, 0, 0, 0, 5);

        // reader of x6 in the same cycle its producer commits
        cmt_valid = 1'b1; cmt_rd = 6; cmt_dest = 2;
        fire_one(0, 6, 0, 0, BYP_QJ, 0, 6);
        cmt_valid = 1'b0;
        fire_one(0, 6, 6, 0, 0, 0, 7);

        // back-pressure: payload held, no allocation while stalled
        drive(7, 0, 0, 1);
        #1;
        chk("in_ready_pre_hold", 128'(in_ready), 128'(1'b1));
        push(0, 0, 8);
        cyc();
        check_out();
        out_ready = 1'b0;
        drive(1, 7, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("in_ready_hold", 128'(in_ready), 128'(1'b0));
            cyc();
            chk("hold_valid", 128'(out_valid), 128'(1'b1));
            chk("hold_fields", 128'({out_qj, out_qk, out_dest, out_rd, out_wen, out_pc, out_inst}),
                128'(last_exp));
        end
        out_ready = 1'b1;
        #1;
        chk("in_ready_release", 128'(in_ready), 128'(1'b1));
        push(8, 0, 1);
        cyc();
        check_out();
        in_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush2_out_valid", 128'(out_valid), 128'(1'b0));
        fire_one(0, 7, 1, 0, 0, 0, 1);

        // reset mid-stream discards the slot and the rename state
        drive(2, 0, 0, 1);
        cyc();
        in_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst2_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst2_out_dest", 128'(out_dest), 128'(0));
        fire_one(0, 2, 0, 0, 0, 0, 1);

        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_rnu.md
YSYX_RNU -- requirements
Module: ysyx_rnu

Interface
REQ-001 SHALL have parameter RLEN, default `YSYX_REG_LEN, architectural register index width.
REQ-002 SHALL have parameter ROB_SIZE, default `YSYX_ROB_SIZE, number of in-flight tags; TW = $clog2(ROB_SIZE)+1.
REQ-003 SHALL have the port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have an input bundle from decode: in_valid (1), in_rd (RLEN), in_rs1 (RLEN), in_rs2 (RLEN), in_wen (1), in_pc (XLEN), in_inst (32).
REQ-006 SHALL drive the output in_ready (1) back to decode.
REQ-007 SHALL have the output bundle to the issue stage: out_valid (1), out_qj (TW), out_qk (TW), out_dest (TW), out_rd (RLEN), out_wen (1), out_pc (XLEN), out_inst (32).
REQ-008 SHALL take the input out_ready (1) from the issue stage.
REQ-009 SHALL take the commit inputs cmt_valid (1), cmt_rd (RLEN), cmt_dest (TW).
REQ-010 SHALL take the input flush (1), a pipeline flush request.

Function
REQ-011 SHALL hold an alias table with one entry {busy, tag[TW]} per architectural register, a tag allocation pointer alloc (1..ROB_SIZE) and an in-flight counter cnt (0..ROB_SIZE).
REQ-012 SHALL use tag value 0 to mean "operand ready in the register file"; tags 1..ROB_SIZE are ROB entries.
REQ-013 SHALL have a single output register slot, with states EMPTY and FULL.
REQ-014 SHALL accept an instruction (fire) when in_valid && in_ready.
REQ-015 SHALL compute in_ready = !flush && cnt < ROB_SIZE && (slot EMPTY || out_ready).
REQ-016 On fire, SHALL load the slot next cycle with: out_qj = busy[rs1] ? tag[rs1] : 0; out_qk likewise for rs2; out_dest = alloc; the remaining fields passed through.
REQ-017 SHALL force out_qj/out_qk to 0 whenever rs1/rs2 equals 0; register x0 SHALL never be renamed.
REQ-018 On fire with in_wen && in_rd != 0, SHALL set busy[rd] = 1 and tag[rd] = alloc.
REQ-019 On fire, SHALL advance alloc by 1, wrapping from ROB_SIZE to 1, and increment cnt; a tag SHALL be allocated even when wen = 0.
REQ-020 On cmt_valid, SHALL decrement cnt, and SHALL clear busy[cmt_rd] only if tag[cmt_rd] == cmt_dest.
REQ-021 When fire and commit occur in the same cycle, cnt SHALL be unchanged.
REQ-022 When a rename write and a commit clear target the same register in the same cycle, the rename write SHALL win.
REQ-023 Slot transitions:
- EMPTY->FULL on fire.
- FULL->EMPTY on out_ready && !fire.
- FULL->FULL on out_ready && fire, or on !out_ready.
REQ-024 SHALL hold all output fields stable while out_valid && !out_ready.
REQ-025 On flush, next cycle SHALL have: all busy = 0, alloc = 1, cnt = 0, slot EMPTY; commit inputs in the flush cycle SHALL be ignored.
REQ-026 Latency SHALL be 1 cycle from fire to out_valid.
REQ-027 Throughput SHALL be 1 instruction per cycle when out_ready stays high and cnt < ROB_SIZE.
REQ-028 out_valid SHALL equal (slot == FULL).

Reset
REQ-029 reset SHALL be synchronous, active-high, and take priority over flush, fire and commit.
REQ-030 After reset: out_valid = 0, in_ready = 1, all busy = 0, all tags = 0, alloc = 1, cnt = 0, and out_qj/out_qk/out_dest/out_rd/out_wen/out_pc/out_inst = 0.
REQ-031 Asserting reset mid-stream SHALL discard the slot contents and all rename state.

Configuration
REQ-032 Macro YSYX_RNU_BYPASS_EN SHALL select commit bypass.
- Defined: a source whose looked-up tag equals cmt_dest with cmt_valid in the fire cycle SHALL output 0 (ready).
- Not defined: the looked-up tag SHALL be output unchanged, and the issue stage resolves it.

Verification
REQ-033 Reset, then fire addi x1 (rd=1, rs1=0, wen=1) -> next cycle out_valid=1, out_dest=1, out_qj=0; busy[1]=1, tag[1]=1.
REQ-034 Back-to-back x1 writer then reader (rs1=1), out_ready=1 -> reader out_qj=1, out_dest=2; alloc=3.
REQ-035 Fire ROB_SIZE instructions with no commit -> in_ready=0 with cnt=ROB_SIZE; one cmt_valid -> in_ready=1 next cycle; the next tag allocated after the wrap is 1.
REQ-036 Stale commit: tag[5]=3, cmt_valid with cmt_rd=5, cmt_dest=2 -> busy[5] stays 1; with cmt_dest=3 -> busy[5]=0.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 -> out_* fields held constant, in_ready=0, no extra tags allocated; then flush -> out_valid=0, alloc=1, all busy=0.
REQ-038 With YSYX_RNU_BYPASS_EN defined, reader of x1 (tag 1) fires while cmt_valid with cmt_dest=1 -> out_qj=0; with the macro undefined -> out_qj=1.
